// File: rtl/core_mem_bridge.sv
// rtl/core_mem_bridge.sv - memory-stage to valid/ready data bus bridge with lane formatting and timeout
module core_mem_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_mem_read_M,
    input  logic                    i_mem_write_M,
    input  logic [2:0]              i_funct3_MEM,
    input  logic [ADDR_WIDTH-1:0]   i_data_addr_M,
    input  logic [DATA_WIDTH-1:0]   i_write_data_M,
    output logic [DATA_WIDTH-1:0]   o_read_data_M,
    output logic                    o_stall,
    output logic                    o_done,
    output logic                    o_misaligned,
    output logic                    o_bus_err,
    output logic                    o_req_valid,
    input  logic                    i_req_ready,
    output logic                    o_req_we,
    output logic [ADDR_WIDTH-1:0]   o_req_addr,
    output logic [DATA_WIDTH-1:0]   o_req_wdata,
    output logic [DATA_WIDTH/8-1:0] o_req_be,
    input  logic                    i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_rsp_rdata,
    input  logic                    i_rsp_err
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

    state_t                  state_q;
    logic [15:0]             cnt_q;
    logic                    we_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_W-1:0]         be_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    access;
    logic                    misal;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [BE_W-1:0]         be_d;
    logic [DATA_WIDTH-1:0]   lane_word;
    logic [DATA_WIDTH-1:0]   load_fmt;
    logic                    idle_fire;

    assign access = i_mem_read_M | i_mem_write_M;

    // Size comes from funct3[1:0]; the reserved encoding 11 behaves as a word.
    always_comb begin
        misal   = 1'b0;
        wdata_d = i_write_data_M;
        be_d    = '1;
        case (i_funct3_MEM[1:0])
            2'b00: begin
                wdata_d = {(DATA_WIDTH/8){i_write_data_M[7:0]}};
                be_d    = {{(BE_W-1){1'b0}}, 1'b1} << i_data_addr_M[1:0];
            end
            2'b01: begin
                misal   = i_data_addr_M[0];
                wdata_d = {(DATA_WIDTH/16){i_write_data_M[15:0]}};
                be_d    = {{(BE_W-2){1'b0}}, 2'b11} << {i_data_addr_M[1], 1'b0};
            end
            default: misal = (i_data_addr_M[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        lane_word = i_rsp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, lane_word[7:0]};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, lane_word[15:0]};
            default: load_fmt = i_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access && !misal) begin
                        state_q  <= S_REQ;
                        cnt_q    <= '0;
                        we_q     <= i_mem_write_M;
                        addr_q   <= {i_data_addr_M[ADDR_WIDTH-1:2], 2'b00};
                        funct3_q <= i_funct3_MEM;
                        off_q    <= i_data_addr_M[1:0];
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        err_q    <= 1'b0;
                        rdata_q  <= '0;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (i_req_ready) begin
                        state_q <= S_RSP;
                    end else if (cnt_q >= TO_LAST) begin
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                S_RSP: begin
                    cnt_q <= cnt_q + 16'd1;
                    // A response arriving on the final allowed cycle still wins over the timeout.
                    if (i_rsp_valid) begin
                        state_q <= S_DONE;
                        err_q   <= i_rsp_err;
                        rdata_q <= we_q ? '0 : load_fmt;
                    end else if (cnt_q >= TO_LAST) begin
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign idle_fire     = !rst && (state_q == S_IDLE) && access;
    assign o_misaligned  = idle_fire && misal;
    assign o_stall       = (idle_fire && !misal)
                         || (!rst && (state_q == S_REQ || state_q == S_RSP));
    assign o_done        = o_misaligned || (!rst && state_q == S_DONE);
    assign o_bus_err     = !rst && (state_q == S_DONE) && err_q;
    assign o_read_data_M = (!rst && state_q == S_DONE) ? rdata_q : '0;
    assign o_req_valid   = !rst && (state_q == S_REQ);
    assign o_req_we      = o_req_valid && we_q;
    assign o_req_addr    = o_req_valid ? addr_q : '0;
    assign o_req_wdata   = o_req_valid ? wdata_q : '0;
    assign o_req_be      = o_req_valid ? be_q : '0;
endmodule

// File: tb/tb_core_mem_bridge.sv
// tb/tb_core_mem_bridge.sv - randomized transaction-level bench for core_mem_bridge
module tb_core_mem_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0, wdata = 32'b0;
    logic        req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_rdata = 32'b0;

    logic [31:0] read_data, req_addr, req_wdata;
    logic        stall, done, misaligned, bus_err, req_valid, req_we;
    logic [3:0]  req_be;

    logic [31:0] t_read_data, t_req_addr, t_req_wdata;
    logic        t_stall, t_done, t_misaligned, t_bus_err, t_req_valid, t_req_we;
    logic [3:0]  t_req_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_mem_bridge dut (
        .clk(clk), .rst(rst),
        .i_mem_read_M(mem_read), .i_mem_write_M(mem_write), .i_funct3_MEM(funct3),
        .i_data_addr_M(addr), .i_write_data_M(wdata),
        .o_read_data_M(read_data), .o_stall(stall), .o_done(done),
        .o_misaligned(misaligned), .o_bus_err(bus_err),
        .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_we(req_we),
        .o_req_addr(req_addr), .o_req_wdata(req_wdata), .o_req_be(req_be),
        .i_rsp_valid(rsp_valid), .i_rsp_rdata(rsp_rdata), .i_rsp_err(rsp_err)
    );

    core_mem_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .i_mem_read_M(mem_read), .i_mem_write_M(mem_write), .i_funct3_MEM(funct3),
        .i_data_addr_M(addr), .i_write_data_M(wdata),
        .o_read_data_M(t_read_data), .o_stall(t_stall), .o_done(t_done),
        .o_misaligned(t_misaligned), .o_bus_err(t_bus_err),
        .o_req_valid(t_req_valid), .i_req_ready(req_ready), .o_req_we(t_req_we),
        .o_req_addr(t_req_addr), .o_req_wdata(t_req_wdata), .o_req_be(t_req_be),
        .i_rsp_valid(rsp_valid), .i_rsp_rdata(rsp_rdata), .i_rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int off;
        n = nbytes(f3);
        off = int'(a[1:0]) - (int'(a[1:0]) % n);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] r);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = nbytes(f3);
        if (n == 4) return r;
        v = r >> (8 * int'(a[1:0]));
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mis"}, 32'(misaligned), 32'd0);
        chk({tag, "_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_rvalid"}, 32'(req_valid), 32'd0);
        chk({tag, "_we"}, 32'(req_we), 32'd0);
        chk({tag, "_rdata"}, read_data, 32'd0);
        chk({tag, "_addr"}, req_addr, 32'd0);
        chk({tag, "_wdata"}, req_wdata, 32'd0);
        chk({tag, "_be"}, 32'(req_be), 32'd0);
    endtask

    // One complete access; the bench plays the bus and checks every cycle against the model.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input int rdly, input int sdly,
                             input logic [31:0] rdata, input bit err, output int stalls);
        int  last;
        bit  in_req, in_rsp, is_done, fin_rsp;
        stalls = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = d;
        req_ready = 1'b0; rsp_valid = 1'b0;
        if (exp_mis(f3, a)) begin
            #1;
            chk("mis_pulse", 32'(misaligned), 32'd1);
            chk("mis_done", 32'(done), 32'd1);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_rvalid", 32'(req_valid), 32'd0);
            chk("mis_rdata", read_data, 32'd0);
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            chk("mis_after_rvalid", 32'(req_valid), 32'd0);
            chk("mis_after_done", 32'(done), 32'd0);
            return;
        end
        last = rdly + sdly + 3;
        for (int j = 0; j <= last; j++) begin
            if (j > 0) @(negedge clk);
            in_req  = (j >= 1) && (j <= rdly + 1);
            in_rsp  = (j >= rdly + 2) && (j <= rdly + sdly + 2);
            is_done = (j == last);
            fin_rsp = (j == last - 1);
            req_ready = in_req ? (j == rdly + 1) : 1'($urandom_range(0, 1));
            rsp_valid = in_rsp ? fin_rsp : ((j == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            rsp_rdata = fin_rsp ? rdata : $urandom;
            rsp_err   = fin_rsp ? err : 1'($urandom_range(0, 1));
            if (is_done) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            #1;
            if (stall) stalls++;
            chk("stall", 32'(stall), 32'(!is_done));
            chk("req_valid", 32'(req_valid), 32'(in_req));
            chk("done", 32'(done), 32'(is_done));
            chk("misaligned", 32'(misaligned), 32'd0);
            if (in_req) begin
                chk("req_addr", req_addr, {a[31:2], 2'b00});
                chk("req_be", 32'(req_be), 32'(exp_be(f3, a)));
                chk("req_wdata", req_wdata, exp_wdata(f3, d));
                chk("req_we", 32'(req_we), 32'(wr));
            end
            if (is_done) begin
                chk("read_data", read_data, wr ? 32'd0 : exp_load(f3, a, rdata));
                chk("bus_err", 32'(bus_err), 32'(err));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        bit rd, wr;

        chk("pin_lb", exp_load(3'b000, 32'h103, 32'h80FF00AA), 32'hFFFFFF80);
        chk("pin_lbu", exp_load(3'b100, 32'h103, 32'h80FF00AA), 32'h00000080);
        chk("pin_lh", exp_load(3'b001, 32'h102, 32'h80FF00AA), 32'hFFFF80FF);
        chk("pin_lw_be", 32'(exp_be(3'b010, 32'h100)), 32'hF);
        chk("pin_sb_be", 32'(exp_be(3'b000, 32'h201)), 32'b0010);
        chk("pin_sb_wd", exp_wdata(3'b000, 32'h12345678), 32'h78787878);
        chk("pin_sh_be", 32'(exp_be(3'b001, 32'h202)), 32'b1100);
        chk("pin_sh_wd", exp_wdata(3'b001, 32'h12345678), 32'h56785678);

        mem_read = 1'b1; addr = 32'h102; funct3 = 3'b010;
        @(negedge clk); #1 chk_zero("in_rst");
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0;
        #1 chk_zero("after_rst");

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, st);
        chk("lw_stalls", 32'(st), 32'd3);
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF00AA, 0, st);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80FF00AA, 0, st);
        do_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF00AA, 0, st);
        do_access(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 0, 32'h0, 0, st);
        do_access(0, 1, 3'b001, 32'h202, 32'h12345678, 0, 0, 32'h0, 1, st);
        do_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0, st);
        chk("mis_stalls", 32'(st), 32'd0);
        do_access(1, 0, 3'b010, 32'h180, 32'h0, 2, 3, 32'hCAFEF00D, 0, st);
        chk("wait_stalls", 32'(st), 32'd8);
        do_access(1, 1, 3'b010, 32'h1C0, 32'hA5A5A5A5, 1, 1, 32'h11111111, 0, st);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            do_access(rd, wr, 3'($urandom), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      ($urandom_range(0, 3) == 0), st);
        end

        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; req_ready = 1'b0; rsp_valid = 1'b0;
        @(negedge clk); req_ready = 1'b1;
        @(negedge clk); req_ready = 1'b0;
        #1 chk("rst_pre_stall", 32'(stall), 32'd1);
        @(negedge clk); rst = 1'b1; mem_read = 1'b0;
        #1 chk_zero("rst_in_rsp");
        @(negedge clk); rst = 1'b0;
        #1 chk_zero("rst_after_rsp");
        do_access(1, 0, 3'b010, 32'h304, 32'h0, 0, 0, 32'h0BADF00D, 0, st);
        chk("post_rst_stalls", 32'(st), 32'd3);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; req_ready = 1'b1; rsp_valid = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 5) mem_read = 1'b0;
            #1;
            chk("to_done", 32'(t_done), 32'(j == 5));
            chk("to_stall", 32'(t_stall), 32'(j < 5));
            chk("to_rvalid", 32'(t_req_valid), 32'(j == 1));
            if (j == 5) begin
                chk("to_err", 32'(t_bus_err), 32'd1);
                chk("to_rdata", t_read_data, 32'd0);
            end
        end
        @(negedge clk); rst = 1'b1; req_ready = 1'b0;
        @(negedge clk); rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
